scr1_tb_axi_rd_burst_split: RTL and testbench

- Testbench-side AXI4 read-burst splitter, placed directly upstream of the testbench AXI memory model. That model only accepts single-beat reads (arlen==0).
- Accepts a multi-beat read burst (FIXED/INCR/WRAP, arlen 0..255) from an upstream master, e.g. the high-speed Y-extension port.
- Issues one single-beat AR per beat to the memory and returns beats upstream with correct rid/rlast.
- One burst in flight; no reordering.

---
 rtl/scr1_tb_axi_rd_burst_split.sv | 127 ++++++++++++
 tb/tb_scr1_tb_axi_rd_burst_split.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tb_axi_rd_burst_split.sv
// AXI4 read-burst splitter: turns one multi-beat AR burst into a series of
// single-beat reads for a memory model that only accepts arlen==0.
module scr1_tb_axi_rd_burst_split #(
   parameter int W_ID   = 4,
   parameter int W_ADR  = 32,
   parameter int W_DATA = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_arvalid,
   input  logic [W_ID-1:0]   s_arid,
   input  logic [W_ADR-1:0]  s_araddr,
   input  logic [1:0]        s_arburst,
   input  logic [2:0]        s_arsize,
   input  logic [7:0]        s_arlen,
   output logic              s_arready,
   output logic              s_rvalid,
   output logic [W_ID-1:0]   s_rid,
   output logic [W_DATA-1:0] s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rlast,
   input  logic              s_rready,
   output logic              m_arvalid,
   output logic [W_ID-1:0]   m_arid,
   output logic [W_ADR-1:0]  m_araddr,
   output logic [1:0]        m_arburst,
   output logic [2:0]        m_arsize,
   output logic [7:0]        m_arlen,
   input  logic              m_arready,
   input  logic              m_rvalid,
   input  logic [W_DATA-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic [W_ID-1:0]   m_rid,
   input  logic              m_rlast,
   output logic              m_rready
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [W_ID-1:0]    r_id;
   logic [W_ADR-1:0]   r_addr;
   logic [1:0]         r_burst;
   logic [2:0]         r_size;
   logic [7:0]         r_len;
   logic [7:0]         r_beat_cnt;
   logic               w_ar_acc;
   logic               w_beat;
   logic               w_last;
   logic               w_unused;

   // Burst address step; WRAP keeps the upper bits of the wrap window fixed.
   function automatic logic [W_ADR-1:0] f_next_addr(
      input logic [W_ADR-1:0] addr,
      input logic [1:0]       burst,
      input logic [2:0]       size,
      input logic [7:0]       len
   );
      logic [W_ADR-1:0] step;
      logic [W_ADR-1:0] wb;
      step = W_ADR'(1) << size;
      wb   = W_ADR'({1'b0, len} + 9'd1) << size;
      case (burst)
         2'b00:   return addr;
         2'b10:   return (addr & ~(wb - W_ADR'(1))) | ((addr + step) & (wb - W_ADR'(1)));
         default: return addr + step;
      endcase
   endfunction

   assign w_ar_acc = s_arvalid && (r_state == ST_IDLE);
   assign w_beat   = (r_state == ST_DATA) && m_rvalid && s_rready;
   assign w_last   = (r_beat_cnt == r_len);
   assign w_unused = ^{m_rid, m_rlast};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ar_acc)
            r_beat_cnt <= '0;
         else if (w_beat && !w_last)
            r_beat_cnt <= r_beat_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_ar_acc) begin
         r_id    <= s_arid;
         r_addr  <= s_araddr;
         r_burst <= s_arburst;
         r_size  <= s_arsize;
         r_len   <= s_arlen;
      end else if (w_beat && !w_last) begin
         r_addr  <= f_next_addr(r_addr, r_burst, r_size, r_len);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_ar_acc)              w_state_nxt = ST_ADDR;
         ST_ADDR: if (m_arready)             w_state_nxt = ST_DATA;
         ST_DATA: if (w_beat)                w_state_nxt = w_last ? ST_IDLE : ST_ADDR;
         default:                            w_state_nxt = ST_IDLE;
      endcase
   end

   // Downstream AR carries the latched burst attributes, one beat at a time.
   assign s_arready = (r_state == ST_IDLE);
   assign m_arvalid = (r_state == ST_ADDR);
   assign m_arid    = r_id;
   assign m_araddr  = r_addr;
   assign m_arburst = r_burst;
   assign m_arsize  = r_size;
   assign m_arlen   = 8'd0;

   assign s_rvalid  = (r_state == ST_DATA) && m_rvalid;
   assign m_rready  = (r_state == ST_DATA) && s_rready;
   assign s_rid     = r_id;
   assign s_rdata   = m_rdata;
   assign s_rresp   = m_rresp;
   assign s_rlast   = (r_state == ST_DATA) && w_last;

endmodule

// File: tb/tb_scr1_tb_axi_rd_burst_split.sv
// Directed bench for the read-burst splitter with a single-beat memory model.
module tb_scr1_tb_axi_rd_burst_split;

   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_arvalid;
   logic [3:0]  s_arid;
   logic [31:0] s_araddr;
   logic [1:0]  s_arburst;
   logic [2:0]  s_arsize;
   logic [7:0]  s_arlen;
   logic        s_arready;
   logic        s_rvalid;
   logic [3:0]  s_rid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rlast;
   logic        s_rready;
   logic        m_arvalid;
   logic [3:0]  m_arid;
   logic [31:0] m_araddr;
   logic [1:0]  m_arburst;
   logic [2:0]  m_arsize;
   logic [7:0]  m_arlen;
   logic        m_arready;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rready;

   int n_vec = 0;
   int n_err = 0;

   logic        ar_toggle = 1'b0;
   logic        mem_tog   = 1'b0;
   logic [31:0] err_addr  = 32'hFFFF_FFFF;

   logic [31:0] exp_addr [4];
   logic [1:0]  exp_resp [4];
   logic [31:0] q_ar_addr [$];
   logic [16:0] q_ar_meta [$];
   logic [38:0] q_r [$];

   scr1_tb_axi_rd_burst_split #(.W_ID(4), .W_ADR(32), .W_DATA(32)) u_dut (
      .clk(clk), .rst(rst),
      .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr),
      .s_arburst(s_arburst), .s_arsize(s_arsize), .s_arlen(s_arlen),
      .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rready(s_rready),
      .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr),
      .m_arburst(m_arburst), .m_arsize(m_arsize), .m_arlen(m_arlen),
      .m_arready(m_arready),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rid(4'h0), .m_rlast(1'b1), .m_rready(m_rready)
   );

   always #5 clk = ~clk;

   // Single-beat memory: registers the read on AR, holds it until taken.
   assign m_arready = ar_toggle ? mem_tog : 1'b1;
   always @(posedge clk) begin
      mem_tog <= ~mem_tog;
      if (rst) begin
         m_rvalid <= 1'b0;
      end else if (m_arvalid && m_arready) begin
         m_rvalid <= 1'b1;
         m_rdata  <= m_araddr ^ KEY;
         m_rresp  <= (m_araddr == err_addr) ? 2'd2 : 2'd0;
      end else if (m_rvalid && m_rready) begin
         m_rvalid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_arvalid && m_arready) begin
         q_ar_addr.push_back(m_araddr);
         q_ar_meta.push_back({m_arid, m_arburst, m_arsize, m_arlen});
      end
      if (s_rvalid && s_rready)
         q_r.push_back({s_rid, s_rdata, s_rresp, s_rlast});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_exp(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3);
      exp_addr[0] = a0; exp_addr[1] = a1; exp_addr[2] = a2; exp_addr[3] = a3;
      for (int i = 0; i < 4; i++) exp_resp[i] = 2'd0;
   endtask

   task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [1:0] burst, input logic [7:0] len);
      int cnt;
      q_ar_addr.delete(); q_ar_meta.delete(); q_r.delete();
      @(negedge clk);
      s_arvalid = 1'b1; s_arid = id; s_araddr = addr;
      s_arburst = burst; s_arsize = 3'd2; s_arlen = len;
      cnt = 0;
      while (!s_arready && cnt < 100) begin @(negedge clk); cnt++; end
      chk("ar_accept_wait", 64'(s_arready), 64'd1);
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      @(negedge clk);
      chk("m_arvalid_after_acc", 64'(m_arvalid), 64'd1);
      chk("s_arready_busy", 64'(s_arready), 64'd0);
   endtask

   task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [1:0] burst, input logic [7:0] len);
      int cnt;
      int n;
      logic [38:0] b;
      n = int'(len) + 1;
      issue_ar(id, addr, burst, len);
      cnt = 0;
      while (q_r.size() < n && cnt < 2000) begin @(negedge clk); #1; cnt++; end
      chk("beat_count", 64'(q_r.size()), 64'(n));
      @(negedge clk);
      chk("s_arready_back", 64'(s_arready), 64'd1);
      chk("ar_count", 64'(q_ar_addr.size()), 64'(n));
      for (int i = 0; i < n && i < q_r.size() && i < q_ar_addr.size(); i++) begin
         b = q_r[i];
         chk($sformatf("m_araddr[%0d]", i), 64'(q_ar_addr[i]), 64'(exp_addr[i]));
         chk($sformatf("m_ar_meta[%0d]", i), 64'(q_ar_meta[i]), 64'({id, burst, 3'd2, 8'd0}));
         chk($sformatf("s_rid[%0d]", i), 64'(b[38:35]), 64'(id));
         chk($sformatf("s_rdata[%0d]", i), 64'(b[34:3]), 64'(exp_addr[i] ^ KEY));
         chk($sformatf("s_rresp[%0d]", i), 64'(b[2:1]), 64'(exp_resp[i]));
         chk($sformatf("s_rlast[%0d]", i), 64'(b[0]), 64'(i == n - 1));
      end
   endtask

   initial begin
      int cnt;
      logic [31:0] d0;
      rst = 1'b1; s_rready = 1'b1; s_arvalid = 1'b0;
      s_arid = '0; s_araddr = '0; s_arburst = '0; s_arsize = '0; s_arlen = '0;
      @(posedge clk); @(negedge clk);
      chk("rst_s_arready", 64'(s_arready), 64'd1);
      chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
      chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
      chk("rst_m_rready", 64'(m_rready), 64'd0);
      chk("rst_m_arlen", 64'(m_arlen), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      set_exp(32'h20, 32'h0, 32'h0, 32'h0);
      run_burst(4'd3, 32'h20, 2'b01, 8'd0);

      set_exp(32'h100, 32'h104, 32'h108, 32'h10C);
      run_burst(4'd5, 32'h100, 2'b01, 8'd3);

      ar_toggle = 1'b1;
      set_exp(32'h10C, 32'h100, 32'h104, 32'h108);
      run_burst(4'd2, 32'h10C, 2'b10, 8'd3);
      ar_toggle = 1'b0;

      set_exp(32'h40, 32'h40, 32'h40, 32'h0);
      run_burst(4'd7, 32'h40, 2'b00, 8'd2);

      set_exp(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
      run_burst(4'd1, 32'hFFFF_FFFC, 2'b01, 8'd1);

      // Stall the upstream on beat 2, which also carries an error response.
      err_addr = 32'h204;
      set_exp(32'h200, 32'h204, 32'h208, 32'h20C);
      exp_resp[1] = 2'd2;
      fork
         run_burst(4'd9, 32'h200, 2'b01, 8'd3);
         begin
            cnt = 0;
            do begin @(posedge clk); #1; cnt++; end while (q_r.size() != 1 && cnt < 200);
            s_rready = 1'b0;
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!s_rvalid && cnt < 50);
            chk("stall_rvalid", 64'(s_rvalid), 64'd1);
            d0 = s_rdata;
            for (int k = 0; k < 5; k++) begin
               chk("stall_rdata", 64'(s_rdata), 64'(d0));
               chk("stall_m_arvalid", 64'(m_arvalid), 64'd0);
               chk("stall_m_rready", 64'(m_rready), 64'd0);
               @(negedge clk);
            end
            s_rready = 1'b1;
         end
      join
      err_addr = 32'hFFFF_FFFF;

      issue_ar(4'd4, 32'h300, 2'b01, 8'd3);
      cnt = 0;
      do begin @(negedge clk); #1; cnt++; end while (!(q_r.size() == 2 && m_arvalid) && cnt < 200);
      chk("reach_beat3_addr", 64'(q_r.size()), 64'd2);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_s_arready", 64'(s_arready), 64'd1);
      chk("midrst_m_arvalid", 64'(m_arvalid), 64'd0);
      chk("midrst_s_rvalid", 64'(s_rvalid), 64'd0);

      set_exp(32'h60, 32'h0, 32'h0, 32'h0);
      run_burst(4'hA, 32'h60, 2'b01, 8'd0);

      set_exp(32'h80, 32'h84, 32'h0, 32'h0);
      run_burst(4'h6, 32'h80, 2'b11, 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
